// File: rtl/instr_fetch_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_queue_if
// Description : Fetch-side bundle. It groups the IF request, the ROM port and
//               the decode handshake of the instruction fetch queue.
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_fetch_queue_if #(
  parameter int PW    = 16,
  parameter int IW    = 9,
  parameter int DEPTH = 4
);
  logic [PW-1:0]              PC;
  logic                       PC_valid;
  logic                       Flush;
  logic                       Fetch_stall;
  logic [PW-1:0]              Rom_addr;
  logic                       Rom_en;
  logic [IW-1:0]              Rom_data;
  logic [IW-1:0]              Instr;
  logic [PW-1:0]              Instr_PC;
  logic                       Instr_valid;
  logic                       Dec_ready;
  logic [$clog2(DEPTH):0]     Count;

  // Environment side: IF stage, ROM and decode
  modport master (
    output PC, PC_valid, Flush, Rom_data, Dec_ready,
    input  Fetch_stall, Rom_addr, Rom_en, Instr, Instr_PC, Instr_valid, Count
  );

  // Queue side
  modport slave (
    input  PC, PC_valid, Flush, Rom_data, Dec_ready,
    output Fetch_stall, Rom_addr, Rom_en, Instr, Instr_PC, Instr_valid, Count
  );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_queue
// Description : Queue between the IF stage and decode. It issues synchronous
//               ROM reads and buffers {instruction, PC} pairs in a FWFT FIFO.
//               Flush and Init drop all queued and in-flight entries.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_queue #(
  parameter int PW    = 16,
  parameter int IW    = 9,
  parameter int DEPTH = 4
) (
  input  wire logic           CLK,
  input  wire logic           Init,
  instr_fetch_queue_if.slave  bus
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = c_AW + 1;
  localparam int c_SW = c_AW + 2;

  logic [c_CW-1:0] r_count;
  logic [c_AW-1:0] r_wptr;
  logic [c_AW-1:0] r_rptr;
  logic            r_pending;
  logic [PW-1:0]   r_req_pc;
  logic [IW-1:0]   r_mem_instr [DEPTH];
  logic [PW-1:0]   r_mem_pc    [DEPTH];

  logic [c_SW-1:0] w_occ;
  logic            w_stall;
  logic            w_accept;
  logic            w_push;
  logic            w_pop;
  logic            w_nonempty;

  // Occupancy includes the in-flight read; a same-cycle pop earns no credit,
  // so the stall depends only on registered state
  assign w_occ      = c_SW'(r_count) + c_SW'(r_pending);
  assign w_stall    = (w_occ >= c_SW'(DEPTH));
  assign w_accept   = bus.PC_valid & ~w_stall & ~bus.Flush & ~Init;
  assign w_push     = r_pending & ~bus.Flush & ~Init;
  assign w_nonempty = (r_count != '0);
  assign w_pop      = w_nonempty & bus.Dec_ready;

  assign bus.Rom_addr    = bus.PC;
  assign bus.Rom_en      = w_accept;
  assign bus.Fetch_stall = w_stall;
  assign bus.Instr_valid = w_nonempty;
  assign bus.Count       = r_count;
  assign bus.Instr       = w_nonempty ? r_mem_instr[r_rptr] : '0;
  assign bus.Instr_PC    = w_nonempty ? r_mem_pc[r_rptr]    : '0;

  // Control state: pointers, occupancy and the one-deep in-flight request
  always_ff @(posedge CLK) begin
    if (Init) begin
      r_count   <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_pending <= 1'b0;
      r_req_pc  <= '0;
    end else if (bus.Flush) begin
      // Pointers realign so the empty queue restarts from a clean slot
      r_count   <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_pending <= 1'b0;
    end else begin
      r_pending <= w_accept;
      if (w_accept) begin
        r_req_pc <= bus.PC;
      end
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        assert (r_count != c_CW'(DEPTH));
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Entry storage; contents are qualified by the occupancy, so no reset
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem_instr[r_wptr] <= bus.Rom_data;
      r_mem_pc[r_wptr]    <= r_req_pc;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_queue
// Description : Directed bench for instr_fetch_queue with a synchronous ROM
//               model whose word at address a is (a*37+5) mod 512.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_queue;

  logic CLK;
  logic Init;
  int   tests;
  int   fails;

  instr_fetch_queue_if #(.PW(16), .IW(9), .DEPTH(4)) bus ();

  instr_fetch_queue #(.PW(16), .IW(9), .DEPTH(4)) dut (
    .CLK  (CLK),
    .Init (Init),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [8:0] rom_f(input logic [15:0] a);
    logic [15:0] t;
    t = a * 16'd37 + 16'd5;
    return t[8:0];
  endfunction

  // Synchronous ROM: data returns one cycle after an enabled read
  always @(posedge CLK) begin
    if (bus.Rom_en) begin
      bus.Rom_data <= rom_f(bus.Rom_addr);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    Init  = 1'b1;
    bus.PC = 16'h1234;
    bus.PC_valid = 1'b1;
    bus.Flush = 1'b0;
    bus.Dec_ready = 1'b0;
    step();
    step();
    chk("rom_en_in_init", 32'(bus.Rom_en), 32'd0);
    chk("rom_addr_comb", 32'(bus.Rom_addr), 32'h1234);

    // Reset state
    Init = 1'b0;
    bus.PC_valid = 1'b0;
    #1;
    chk("rst_count", 32'(bus.Count), 32'd0);
    chk("rst_valid", 32'(bus.Instr_valid), 32'd0);
    chk("rst_stall", 32'(bus.Fetch_stall), 32'd0);
    chk("rst_instr", 32'(bus.Instr), 32'd0);
    chk("rst_ipc", 32'(bus.Instr_PC), 32'd0);
    chk("rst_rom_en", 32'(bus.Rom_en), 32'd0);

    // Streaming: PC k accepted in cycle k shows at head in cycle k+2
    bus.Dec_ready = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      chk("strm_count", 32'(bus.Count), (k >= 2 && k <= 7) ? 32'd1 : 32'd0);
      chk("strm_stall", 32'(bus.Fetch_stall), 32'd0);
      chk("strm_valid", 32'(bus.Instr_valid), (k >= 2 && k <= 7) ? 32'd1 : 32'd0);
      if (k >= 2 && k <= 7) begin
        chk("strm_ipc", 32'(bus.Instr_PC), 32'(k - 2));
        chk("strm_instr", 32'(bus.Instr), 32'(rom_f(16'(k - 2))));
      end
      bus.PC = 16'(k);
      bus.PC_valid = (k < 6);
      step();
    end
    bus.PC_valid = 1'b0;

    // Fill and stall: 10..13 accepted, 14 held off
    bus.Dec_ready = 1'b0;
    for (int k = 0; k <= 5; k++) begin
      chk("fill_count", 32'(bus.Count), (k == 0) ? 32'd0 : 32'(k - 1));
      chk("fill_stall", 32'(bus.Fetch_stall), (k >= 4) ? 32'd1 : 32'd0);
      bus.PC = 16'(10 + (k > 4 ? 4 : k));
      bus.PC_valid = 1'b1;
      #1;
      chk("fill_rom_en", 32'(bus.Rom_en), (k < 4) ? 32'd1 : 32'd0);
      step();
    end
    bus.PC_valid = 1'b0;
    chk("full_count", 32'(bus.Count), 32'd4);
    chk("full_stall", 32'(bus.Fetch_stall), 32'd1);
    bus.Dec_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      chk("drain_ipc", 32'(bus.Instr_PC), 32'(10 + j));
      chk("drain_instr", 32'(bus.Instr), 32'(rom_f(16'(10 + j))));
      step();
    end
    chk("drain_empty", 32'(bus.Instr_valid), 32'd0);
    chk("drain_instr0", 32'(bus.Instr), 32'd0);

    // Flush with two queued and one in flight; pop on the flush cycle
    bus.Dec_ready = 1'b0;
    bus.PC_valid = 1'b1;
    bus.PC = 16'd20; step();
    bus.PC = 16'd21; step();
    bus.PC = 16'd22; step();
    chk("pre_flush_count", 32'(bus.Count), 32'd2);
    bus.Flush = 1'b1;
    bus.PC = 16'd40;
    bus.Dec_ready = 1'b1;
    #1;
    chk("flush_drop_pc", 32'(bus.Rom_en), 32'd0);
    step();
    bus.Flush = 1'b0;
    bus.Dec_ready = 1'b0;
    chk("flush_count", 32'(bus.Count), 32'd0);
    chk("flush_valid", 32'(bus.Instr_valid), 32'd0);
    #1;
    chk("refetch_rom_en", 32'(bus.Rom_en), 32'd1);
    step();
    bus.PC_valid = 1'b0;
    chk("no_stale_22", 32'(bus.Instr_valid), 32'd0);
    step();
    chk("refetch_valid", 32'(bus.Instr_valid), 32'd1);
    chk("refetch_ipc", 32'(bus.Instr_PC), 32'd40);
    chk("refetch_instr", 32'(bus.Instr), 32'(rom_f(16'd40)));
    bus.Dec_ready = 1'b1;
    step();
    bus.Dec_ready = 1'b0;
    chk("refetch_popped", 32'(bus.Count), 32'd0);

    // Push/pop at full, storage wraps through index 0
    bus.PC_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.PC = 16'(50 + k);
      step();
    end
    bus.PC_valid = 1'b0;
    step();
    chk("wrap_full", 32'(bus.Count), 32'd4);
    bus.Dec_ready = 1'b1;
    bus.PC = 16'd54;
    bus.PC_valid = 1'b1;
    #1;
    chk("no_pop_credit", 32'(bus.Rom_en), 32'd0);
    step();
    bus.Dec_ready = 1'b0;
    chk("wrap_count3", 32'(bus.Count), 32'd3);
    chk("wrap_head51", 32'(bus.Instr_PC), 32'd51);
    #1;
    chk("wrap_accept54", 32'(bus.Rom_en), 32'd1);
    step();
    bus.PC_valid = 1'b0;
    step();
    chk("wrap_refull", 32'(bus.Count), 32'd4);
    bus.Dec_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      chk("wrap_ipc", 32'(bus.Instr_PC), 32'(51 + j));
      chk("wrap_instr", 32'(bus.Instr), 32'(rom_f(16'(51 + j))));
      step();
    end
    bus.Dec_ready = 1'b0;

    // Init mid-stream with three queued and one in flight
    bus.PC_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.PC = 16'(60 + k);
      step();
    end
    chk("pre_init_count", 32'(bus.Count), 32'd3);
    bus.PC_valid = 1'b0;
    Init = 1'b1;
    step();
    Init = 1'b0;
    #1;
    chk("init_count", 32'(bus.Count), 32'd0);
    chk("init_valid", 32'(bus.Instr_valid), 32'd0);
    chk("init_instr", 32'(bus.Instr), 32'd0);
    chk("init_ipc", 32'(bus.Instr_PC), 32'd0);
    chk("init_stall", 32'(bus.Fetch_stall), 32'd0);
    chk("init_rom_en", 32'(bus.Rom_en), 32'd0);
    for (int j = 0; j < 3; j++) begin
      step();
      chk("init_no_stale", 32'(bus.Instr_valid), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 The block SHALL have parameter PW, default 16, meaning program counter width.
REQ-002 The block SHALL have parameter IW, default 9, meaning instruction width.
REQ-003 The block SHALL have parameter DEPTH, default 4, meaning queue entries (power of two, >= 2).
REQ-004 The block SHALL have one clock, CLK, with reset Init synchronous and active-high.
REQ-005 The block SHALL provide these ports:
- CLK  in  1  clock; all state changes on posedge only
- Init  in  1  synchronous active-high reset
- PC  in  PW  fetch address from the IF stage
- PC_valid  in  1  PC is a fetch request this cycle
- Flush  in  1  branch redirect; discard all queued and in-flight instructions
- Fetch_stall  out  1  IF must hold PC; request not accepted
- Rom_addr  out  PW  synchronous instruction ROM address
- Rom_en  out  1  ROM read enable
- Rom_data  in  IW  ROM read data, valid one cycle after Rom_en
- Instr  out  IW  head instruction to decode
- Instr_PC  out  PW  PC of head instruction
- Instr_valid  out  1  head entry present
- Dec_ready  in  1  decode consumes head this cycle
- Count  out  $clog2(DEPTH)+1  current occupancy

Function
REQ-006 Rom_addr SHALL equal PC combinationally at all times.
REQ-007 Rom_en SHALL be PC_valid & ~Fetch_stall & ~Flush & ~Init; a request is accepted exactly when Rom_en=1.
REQ-008 On acceptance in cycle N, the block SHALL register pending=1 and req_pc=PC; in cycle N+1 it SHALL write {Rom_data, req_pc} to the tail.
REQ-009 The written entry SHALL appear as Instr_valid=1 no earlier than cycle N+2; the minimum PC-to-Instr latency is 2 cycles.
REQ-010 Fetch_stall SHALL be 1 when Count + pending >= DEPTH, computed from registered state only, with no credit for a same-cycle pop.
REQ-011 Occupancy SHALL never exceed DEPTH; an overflow write is unreachable by construction and SHALL be flagged by an assertion.
REQ-012 Instr_valid SHALL equal (Count != 0); the head SHALL be first-word fall-through.
REQ-013 When Count=0, Instr and Instr_PC SHALL be driven to 0.
REQ-014 A pop SHALL occur when Instr_valid & Dec_ready; Dec_ready with an empty queue SHALL be ignored.
REQ-015 Simultaneous push and pop SHALL leave Count unchanged and advance both pointers.
REQ-016 Read and write pointers SHALL wrap modulo DEPTH.
REQ-017 Flush SHALL set Count=0 and pending=0 on the next edge.
REQ-018 When Flush is high, any Rom_data returning in that cycle SHALL be discarded.
REQ-019 A PC presented in the same cycle as Flush SHALL be dropped, not accepted; IF re-presents the target the following cycle.
REQ-020 Flush SHALL take priority over push and pop; a pop coinciding with Flush SHALL still drop the entry.
REQ-021 Entries SHALL be delivered in acceptance order with no duplication or loss, except on Flush.

Reset
REQ-022 While Init=1, at the next edge the block SHALL clear Count, both pointers, pending and req_pc to 0.
REQ-023 After reset, Instr_valid, Fetch_stall and Rom_en SHALL be 0, and Instr and Instr_PC SHALL be 0.
REQ-024 Init asserted mid-operation SHALL discard queued and in-flight data exactly as Flush does, and take priority over Flush.
REQ-025 Queue storage contents SHALL NOT require reset.

Verification
REQ-026 Streaming: PC=0..5 with PC_valid=1 and Dec_ready=1 each cycle -> Instr_PC 0..5 appear on consecutive cycles starting 2 cycles after PC=0; Count stays <= 2; Fetch_stall never asserts.
REQ-027 Fill and stall: Dec_ready=0, PC=10,11,12,13,14 on consecutive cycles -> 10-13 are accepted and 14 is stalled (Fetch_stall=1 from the cycle Count+pending=4); Count=4; Dec_ready=1 drains 10,11,12,13 in order.
REQ-028 Flush: queue holds PCs 20,21 with 22 in flight, Flush=1 with PC=40 -> 40 is dropped; the next cycle Count=0 and Instr_valid=0; 22's data never appears; PC=40 re-presented is delivered 2 cycles later.
REQ-029 Simultaneous push and pop at full: Count=4, pending=0, Dec_ready=1 -> Count=3 the next cycle; a newly accepted PC lands after the existing 3 with order preserved; pointers wrap through index 0.
REQ-030 Reset mid-stream: Init=1 for one cycle with Count=3 and pending=1 -> all outputs 0 the next cycle; no stale instruction emerges afterward.
REQ-031 Random: randomized PC_valid, Dec_ready and Flush (5%) -> a scoreboard sees in-order delivery, Count <= DEPTH, and each Instr equals ROM[Instr_PC].
